// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin share of one registered valid/ready slot among N sources, locked for BEAT beats per grant
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int BEAT  = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [N-1:0]         iValid_AM,
    output logic [N-1:0]         oReady_AM,
    input  logic [N*WIDTH-1:0]   iData_AM,
    output logic                 oValid_BM,
    input  logic                 iReady_BM,
    output logic [WIDTH-1:0]     oData_BM,
    output logic [$clog2(N)-1:0] oGrant_BM,
    output logic                 oLast_BM
);
    localparam int GW = $clog2(N);
    localparam int CW = BEAT > 1 ? $clog2(BEAT) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [GW-1:0] grant, ptr, pick, idx;
    logic [CW-1:0] count;
    logic          free, xfer, last, found;

    // handshake decode: only the locked requester may see ready, and only when the slot can take a beat
    always_comb begin
        free      = !oValid_BM || iReady_BM;
        last      = count == CW'(BEAT - 1);
        xfer      = state == LOCK && iValid_AM[grant] && free;
        oReady_AM = (state == LOCK && free) ? {{(N-1){1'b0}}, 1'b1} << grant : '0;
    end

    // first valid requester after the last grant, wrapping modulo N
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = GW'((int'(ptr) + i) % N);
            if (!found && iValid_AM[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // grant FSM plus the output slot; the slot only drops valid when downstream takes it
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            grant     <= '0;
            count     <= '0;
            ptr       <= GW'(N - 1);
            oValid_BM <= 1'b0;
            oData_BM  <= '0;
            oGrant_BM <= '0;
            oLast_BM  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (|iValid_AM) begin
                    grant <= pick;
                    count <= '0;
                    state <= LOCK;
                end
            end else if (xfer) begin
                count <= last ? '0 : count + 1'b1;
                if (last) begin
                    ptr   <= grant;
                    state <= IDLE;
                end
            end
            if (xfer) begin
                oValid_BM <= 1'b1;
                oData_BM  <= iData_AM[grant*WIDTH +: WIDTH];
                oGrant_BM <= grant;
                oLast_BM  <= last;
            end else if (iReady_BM) begin
                oValid_BM <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scoreboard bench for stream_rr_arbiter with BEAT=4 bursts
module tb_stream_rr_arbiter;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int BEAT = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   ready;
    logic [N*W-1:0] data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [1:0]     out_grant;
    logic           out_last;

    int           rem[N] = '{default: 0};
    logic [W-1:0] nd[N]  = '{default: '0};
    logic [N-1:0] hs     = '0;
    logic         rdy    = 1'b1;
    int           cyc    = 0;
    int           n_chk  = 0;
    int           n_fail = 0;
    logic [10:0]  exp_q[$];
    int           p_cyc[$];

    always #5 clk = ~clk;

    stream_rr_arbiter #(.N(N), .WIDTH(W), .BEAT(BEAT)) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iValid_AM (valid),
        .oReady_AM (ready),
        .iData_AM  (data),
        .oValid_BM (out_valid),
        .iReady_BM (out_ready),
        .oData_BM  (out_data),
        .oGrant_BM (out_grant),
        .oLast_BM  (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic load(input int k, input int n, input logic [W-1:0] start);
        rem[k] = n;
        nd[k]  = start;
    endtask

    task automatic push_burst(input int g, input logic [W-1:0] start);
        for (int i = 0; i < BEAT; i++)
            exp_q.push_back({i == BEAT - 1, 2'(g), start + W'(i)});
    endtask

    // one clock: retire last cycle's upstream handshakes, drive inputs, then score any beat leaving the slot
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (hs[k]) begin
                rem[k]--;
                nd[k]++;
            end
        end
        for (int k = 0; k < N; k++) begin
            valid[k]         = rem[k] > 0;
            data[k*W +: W]   = nd[k];
        end
        out_ready = rdy;
        #1;
        hs = rst ? '0 : valid & ready;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_beat_qsize", exp_q.size(), 1);
            else chk("beat", {out_last, out_grant, out_data}, exp_q.pop_front());
            p_cyc.push_back(cyc);
        end
    endtask

    task automatic run(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        // reset with every requester pending; ptr=N-1 means requester 0 wins first, then 1,2,3
        for (int k = 0; k < N; k++) begin
            load(k, BEAT, W'(8'h80 + k * 8'h10));
            push_burst(k, W'(8'h80 + k * 8'h10));
        end
        rst = 1'b1;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", ready, 0);
        chk("rst_grant", out_grant, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        run(60);

        // single requester, two bursts: back-to-back beats, one bubble between bursts
        p_cyc.delete();
        load(0, 2 * BEAT, 8'h10);
        push_burst(0, 8'h10);
        push_burst(0, 8'h14);
        run(40);
        chk("single_burst_span", p_cyc[3] - p_cyc[0], 3);
        chk("single_bubble", p_cyc[4] - p_cyc[3], 2);

        // contention: last grant was 0, so 1 goes first and they alternate
        p_cyc.delete();
        load(0, 2 * BEAT, 8'h20);
        load(1, 2 * BEAT, 8'h40);
        push_burst(1, 8'h40);
        push_burst(0, 8'h20);
        push_burst(1, 8'h44);
        push_burst(0, 8'h24);
        run(60);
        chk("cont_bubble", p_cyc[4] - p_cyc[3], 2);
        chk("cont_span", p_cyc[7] - p_cyc[4], 3);

        // fairness: after 2 finishes, 0/2/3 pending -> 3, 0, 2
        load(2, BEAT, 8'h60);
        push_burst(2, 8'h60);
        run(20);
        load(0, BEAT, 8'h00);
        load(2, BEAT, 8'h30);
        load(3, BEAT, 8'h50);
        push_burst(3, 8'h50);
        push_burst(0, 8'h00);
        push_burst(2, 8'h30);
        run(60);

        // backpressure mid-burst: slot frozen on 0x72, no upstream ready, then resumes cleanly
        load(1, BEAT, 8'h70);
        push_burst(1, 8'h70);
        rdy = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() > 2; n++) step();
        chk("bp_reach", exp_q.size(), 2);
        rdy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h72);
            chk("bp_grant", out_grant, 1);
            chk("bp_last", out_last, 0);
            chk("bp_ready", ready, 0);
        end
        rdy = 1'b1;
        run(20);

        // stall: requester 2 sends 1 of 4 beats and drops valid; lock stays on 2, 3 never gets ready
        load(2, 1, 8'h90);
        load(3, BEAT, 8'hA0);
        exp_q.push_back({1'b0, 2'd2, 8'h90});
        for (int n = 0; n < 6; n++) begin
            step();
            chk("stall_other_ready", ready & 4'b1011, 0);
        end
        chk("stall_beat_out", exp_q.size(), 0);
        chk("stall_lock_ready", ready, 4'b0100);
        rst = 1'b1;
        load(3, 0, 8'h00);
        step();
        step();
        chk("stall_rst_valid", out_valid, 0);
        chk("stall_rst_ready", ready, 0);
        rst = 1'b0;
        step();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_ready", ready, 0);
        load(1, BEAT, 8'hB0);
        push_burst(1, 8'hB0);
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
